hd_pad_link: RTL and testbench

HD_PAD_LINK -- requirements
Module: hd_pad_link

---
 rtl/hd_pad_link.sv | 146 ++++++++++++++
 tb/tb_hd_pad_link.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hd_pad_link.sv
// rtl/hd_pad_link.sv - half-duplex single-wire link controller driving a registered bidirectional IOB
module hd_pad_link #(
  parameter int CLKS_PER_BIT = 4,
  parameter int TURN_CYCLES  = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy,
  output logic       pad_i,
  output logic       pad_t,
  input  logic       pad_o
);

  localparam int CMAX = (CLKS_PER_BIT > TURN_CYCLES) ? CLKS_PER_BIT : TURN_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [3:0]    STOP_IDX  = 4'd9;

  typedef enum logic [2:0] {S_IDLE, S_TX, S_TURN, S_RX_WAIT, S_RX} state_t;

  state_t         state, next_state;
  logic [CW-1:0]  cnt;
  logic [3:0]     bcnt;
  logic [TW-1:0]  tcnt;
  logic [7:0]     tx_byte;
  logic [7:0]     rx_shift;
  logic [15:0]    tx_frame;

  logic accept, tx_bit_end, rx_sample, rx_stop, to_hit;
  logic pad_t_d, pad_i_d, tx_ready_d, busy_d, rx_valid_d, rx_err_d;

  // Frame bits indexed by bit number: start, d0..d7, stop; upper padding keeps index+1 in range.
  assign tx_frame   = {6'h3f, 1'b1, tx_byte, 1'b0};
  assign accept     = (state == S_IDLE) && tx_valid && tx_ready;
  assign tx_bit_end = (cnt == BIT_LAST);
  assign rx_sample  = (bcnt == 4'd0) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
  assign rx_stop    = rx_sample && (bcnt == STOP_IDX);
  assign to_hit     = pad_o && (tcnt == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (accept) next_state = S_TX;
      S_TX:      if (tx_bit_end && bcnt == STOP_IDX) next_state = S_TURN;
      S_TURN:    if (cnt == TURN_LAST) next_state = S_RX_WAIT;
      S_RX_WAIT: begin
        if (!pad_o)      next_state = S_RX;
        else if (to_hit) next_state = S_IDLE;
      end
      S_RX: begin
        if (rx_sample && bcnt == 4'd0 && pad_o) next_state = S_RX_WAIT;
        else if (rx_stop)                       next_state = S_IDLE;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  // Output decode: next-cycle values of every registered output.
  always_comb begin
    pad_t_d = (next_state == S_TX);
    pad_i_d = 1'b1;
    if (next_state == S_TX) begin
      if (state == S_IDLE)  pad_i_d = 1'b0;
      else if (tx_bit_end)  pad_i_d = tx_frame[bcnt + 4'd1];
      else                  pad_i_d = tx_frame[bcnt];
    end
    tx_ready_d = (next_state == S_IDLE);
    busy_d     = (next_state != S_IDLE);
    rx_valid_d = (state == S_RX) && rx_stop && pad_o;
    rx_err_d   = ((state == S_RX) && rx_stop && !pad_o) || ((state == S_RX_WAIT) && to_hit);
  end

  // Registered outputs; rx_data only moves on a good stop bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      pad_t    <= 1'b0;
      pad_i    <= 1'b1;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      tx_ready <= tx_ready_d;
      busy     <= busy_d;
      pad_t    <= pad_t_d;
      pad_i    <= pad_i_d;
      rx_valid <= rx_valid_d;
      rx_err   <= rx_err_d;
      if (rx_valid_d) rx_data <= rx_shift;
    end
  end

  // Counters and shift registers; the timeout counter survives false starts (RX -> RX_WAIT).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      bcnt     <= '0;
      tcnt     <= '0;
      tx_byte  <= 8'h00;
      rx_shift <= 8'h00;
    end else begin
      if (accept) tx_byte <= tx_data;

      if (next_state != state) begin
        cnt  <= '0;
        bcnt <= '0;
      end else if ((state == S_TX && tx_bit_end) || (state == S_RX && rx_sample)) begin
        cnt  <= '0;
        bcnt <= bcnt + 4'd1;
      end else if (state == S_TX || state == S_RX || state == S_TURN) begin
        cnt  <= cnt + 1'b1;
      end

      if (state == S_RX && rx_sample && bcnt != 4'd0 && bcnt != STOP_IDX)
        rx_shift <= {pad_o, rx_shift[7:1]};

      if (state == S_RX_WAIT) begin
        if (pad_o) tcnt <= tcnt + 1'b1;
      end else if (state != S_RX) begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hd_pad_link.sv
// tb/tb_hd_pad_link.sv - self-checking bench for hd_pad_link
module tb_hd_pad_link;

  localparam int CPB  = 4;
  localparam int TURN = 2;
  localparam int TO   = 64;
  localparam int HALF = CPB / 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;
  logic       pad_i;
  logic       pad_t;
  logic       pad_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] last_good = 8'h00;

  hd_pad_link #(.CLKS_PER_BIT(CPB), .TURN_CYCLES(TURN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy),
    .pad_i(pad_i), .pad_t(pad_t), .pad_o(pad_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    bit         present;
    logic [7:0] rb;
    bit         rs;
    int         d;
    int         g;
    bit         junk;
    bit         hold;
    bit         ev;
    bit         ee;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Line bit k of a frame carrying byte b: start, d0..d7 (LSB first), stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Responder pad value for cycle rel after accept (rel 42 is the first listening cycle).
  function automatic logic resp_bit(input int rel, input bit present, input logic [7:0] rb,
                                    input bit rs, input int d, input int g, input bit junk);
    int r;
    if (rel < 10*CPB) return 1'b1;
    if (rel < 10*CPB + TURN) return junk ? logic'($urandom_range(0, 1)) : 1'b1;
    r = rel - (10*CPB + TURN);
    if (g >= 0 && r == g) return 1'b0;
    if (present && r >= d && r < d + 10*CPB) begin
      if ((r - d) / CPB == 9) return rs;
      return frame_bit(rb, (r - d) / CPB);
    end
    return 1'b1;
  endfunction

  task automatic run_txn(input string lbl, input vec_t v);
    int evt, guard;
    int bad_t, bad_i, bad_v, bad_e, bad_r, bad_b, bad_d;
    logic [7:0] x_data;
    evt = v.present ? (10*CPB + TURN + v.d + HALF + 9*CPB + 1) : (10*CPB + TURN + TO);
    bad_t = 0; bad_i = 0; bad_v = 0; bad_e = 0; bad_r = 0; bad_b = 0; bad_d = 0;
    guard = 0;
    while (tx_ready !== 1'b1 && guard < 400) begin @(negedge clk); guard++; end
    chk({lbl, "_ready_wait"}, guard < 400, 1);
    tx_data = v.tx; tx_valid = 1'b1; pad_o = 1'b1;
    @(negedge clk);
    if (!v.hold) tx_valid = 1'b0;
    for (int rel = 0; rel <= evt; rel++) begin
      x_data = (rel == evt && v.ev) ? v.ed : last_good;
      if (pad_t !== (rel < 10*CPB)) bad_t++;
      if (pad_i !== ((rel < 10*CPB) ? frame_bit(v.tx, rel / CPB) : 1'b1)) bad_i++;
      if (rx_valid !== (v.ev && rel == evt)) bad_v++;
      if (rx_err !== (v.ee && rel == evt)) bad_e++;
      if (tx_ready !== (rel == evt)) bad_r++;
      if (busy !== (rel != evt)) bad_b++;
      if (rx_data !== x_data) bad_d++;
      pad_o = resp_bit(rel, v.present, v.rb, v.rs, v.d, v.g, v.junk);
      @(negedge clk);
    end
    pad_o = 1'b1;
    chk({lbl, "_pad_t_bad_cycles"}, bad_t, 0);
    chk({lbl, "_pad_i_bad_cycles"}, bad_i, 0);
    chk({lbl, "_rx_valid_bad_cycles"}, bad_v, 0);
    chk({lbl, "_rx_err_bad_cycles"}, bad_e, 0);
    chk({lbl, "_tx_ready_bad_cycles"}, bad_r, 0);
    chk({lbl, "_busy_bad_cycles"}, bad_b, 0);
    chk({lbl, "_rx_data_bad_cycles"}, bad_d, 0);
    if (v.ev) last_good = v.ed;
    if (v.hold) begin
      chk({lbl, "_requeue_pad_t_pad_i"}, {pad_t, pad_i}, 2'b10);
      tx_valid = 1'b0;
      guard = 0;
      while (tx_ready !== 1'b1 && guard < 400) begin @(negedge clk); guard++; end
      chk({lbl, "_drain_wait"}, guard < 400, 1);
      chk({lbl, "_drain_rx_data"}, rx_data, last_good);
    end else begin
      chk({lbl, "_after_t_v_e_r"}, {pad_t, rx_valid, rx_err, tx_ready}, 4'b0001);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int kind;
    //         tx     pres rb     rs  d   g   junk hold ev  ee  ed
    tbl[0] = '{8'hA5, 1,   8'h3C, 1,  0,  -1, 0,   0,   1,  0,  8'h3C};
    tbl[1] = '{8'h5A, 1,   8'hFF, 0,  3,  -1, 0,   0,   0,  1,  8'h00};
    tbl[2] = '{8'h00, 0,   8'h00, 1,  0,  -1, 0,   0,   0,  1,  8'h00};
    tbl[3] = '{8'hFF, 1,   8'h81, 1,  10, 1,  0,   0,   1,  0,  8'h81};
    tbl[4] = '{8'hC3, 1,   8'h00, 1,  63, -1, 0,   0,   1,  0,  8'h00};
    tbl[5] = '{8'h12, 1,   8'h7E, 1,  2,  -1, 1,   0,   1,  0,  8'h7E};
    tbl[6] = '{8'h66, 1,   8'h99, 1,  4,  -1, 0,   1,   1,  0,  8'h99};

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; pad_o = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pad_t", pad_t, 0);
    chk("reset_pad_i", pad_i, 1);
    chk("reset_tx_ready", tx_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {rx_valid, rx_err}, 2'b00);
    chk("reset_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge_tx_ready", tx_ready, 1);

    for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Reset pulse during TX bit 3 aborts cleanly.
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (13) @(negedge clk);
    chk("midtx_bit3_pad", {pad_t, pad_i}, {1'b1, frame_bit(8'hA5, 3)});
    rst_n = 1'b0;
    @(negedge clk);
    chk("midtx_reset_pad", {pad_t, pad_i}, 2'b01);
    chk("midtx_reset_flags", {tx_ready, busy, rx_valid, rx_err}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midtx_release_ready", {tx_ready, pad_t}, 2'b10);
    last_good = 8'h00;
    chk("midtx_rx_data", rx_data, last_good);
    kind = 0;
    repeat (5) begin
      if (rx_valid || rx_err || pad_t) kind++;
      @(negedge clk);
    end
    chk("midtx_quiet_cycles", kind, 0);

    // Randomized transactions checked against the frame-level model.
    for (int i = 0; i < 16; i++) begin
      kind      = $urandom_range(0, 9);
      v.tx      = 8'($urandom);
      v.rb      = 8'($urandom);
      v.present = (kind < 8);
      v.rs      = (kind < 6);
      v.d       = $urandom_range(0, 30);
      v.g       = (v.present && v.d >= 3 && $urandom_range(0, 2) == 0) ? $urandom_range(0, v.d - 3) : -1;
      v.junk    = 1'($urandom_range(0, 1));
      v.hold    = 1'b0;
      v.ev      = v.present && v.rs;
      v.ee      = !(v.present && v.rs);
      v.ed      = v.rb;
      run_txn($sformatf("rnd%0d", i), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
